// File: rtl/bram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous BRAM.
// A built-in sequencer can zero-fill the whole memory while both masters
// are stalled. Read data is routed back to the master that issued the read.
module bram_arbiter #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9
) (
  input  logic                     clock,
  input  logic                     reset_n,
  // master 0
  input  logic                     m0_req,
  input  logic                     m0_we,
  input  logic [RAM_ADDR_BITS-1:0] m0_addr,
  input  logic [RAM_WIDTH-1:0]     m0_wdata,
  output logic                     m0_gnt,
  output logic                     m0_rvalid,
  output logic [RAM_WIDTH-1:0]     m0_rdata,
  // master 1
  input  logic                     m1_req,
  input  logic                     m1_we,
  input  logic [RAM_ADDR_BITS-1:0] m1_addr,
  input  logic [RAM_WIDTH-1:0]     m1_wdata,
  output logic                     m1_gnt,
  output logic                     m1_rvalid,
  output logic [RAM_WIDTH-1:0]     m1_rdata,
  // clear sequencer
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic                     clear_done,
  // BRAM port
  output logic                     ram_enable,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] address,
  output logic [RAM_WIDTH-1:0]     input_data,
  input  logic [RAM_WIDTH-1:0]     output_data
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  // Terminal address of the zero-fill; compared explicitly, never by overflow.
  localparam logic [RAM_ADDR_BITS-1:0] CNT_LAST = '1;
  localparam logic [RAM_ADDR_BITS-1:0] CNT_ONE  = {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};

  logic [0:0]               state;
  logic [RAM_ADDR_BITS-1:0] counter;
  logic                     last_grant;   // 0 = master 0 won last, 1 = master 1
  logic                     idle;

  assign idle       = (state == IDLE);
  assign clear_busy = (state == CLEAR);

  // Round-robin grant: a lone requester always wins; on a tie the master
  // that did not win last time is served.
  always_comb begin
    m0_gnt = idle & m0_req & (~m1_req | last_grant);
    m1_gnt = idle & m1_req & (~m0_req | ~last_grant);
  end

  // BRAM port mux: clear sequencer has priority, then the granted master.
  always_comb begin
    ram_enable   = 1'b0;
    write_enable = 1'b0;
    address      = '0;
    input_data   = '0;
    if (state == CLEAR) begin
      ram_enable   = 1'b1;
      write_enable = 1'b1;
      address      = counter;
      input_data   = '0;
    end else if (m0_gnt) begin
      ram_enable   = 1'b1;
      write_enable = m0_we;
      address      = m0_addr;
      input_data   = m0_wdata;
    end else if (m1_gnt) begin
      ram_enable   = 1'b1;
      write_enable = m1_we;
      address      = m1_addr;
      input_data   = m1_wdata;
    end
  end

  // Both masters see the BRAM output; rvalid tells each whether it is theirs.
  assign m0_rdata = output_data;
  assign m1_rdata = output_data;

  // Read-return tracking and round-robin history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt) begin
        last_grant <= 1'b0;
      end else if (m1_gnt) begin
        last_grant <= 1'b1;
      end
    end
  end

  // Clear sequencer: walks every address once, then pulses clear_done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      counter    <= '0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state   <= CLEAR;
            counter <= '0;
          end
        end
        CLEAR: begin
          if (counter == CNT_LAST) begin
            state      <= IDLE;
            counter    <= '0;
            clear_done <= 1'b1;
          end else begin
            counter <= counter + CNT_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter with a behavioural single-port BRAM.
module tb_bram_arbiter;

  localparam int W  = 32;
  localparam int AB = 9;
  localparam int DEPTH = 1 << AB;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AB-1:0] m0_addr = '0, m1_addr = '0;
  logic [W-1:0]  m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [W-1:0]  m0_rdata, m1_rdata;
  logic          clear_start = 0, clear_busy, clear_done;
  logic          ram_enable, write_enable;
  logic [AB-1:0] address;
  logic [W-1:0]  input_data;
  logic [W-1:0]  output_data = '0;

  int tests = 0;
  int fails = 0;

  bram_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_enable(ram_enable), .write_enable(write_enable), .address(address),
    .input_data(input_data), .output_data(output_data)
  );

  always #5 clock = ~clock;

  // Behavioural single-port BRAM, 1-cycle read latency, holds output when disabled.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_enable) begin
      if (write_enable) mem[address] <= input_data;
      output_data <= mem[address];
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic do_write(input logic [AB-1:0] a, input logic [W-1:0] d);
    bit got = 0;
    m0_req = 1; m0_we = 1; m0_addr = a; m0_wdata = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (m0_gnt) got = 1;
      else begin @(posedge clock); #1; end
    end
    if (!got) chk("write_grant_timeout", 0, 1);
    @(posedge clock); #1;
    m0_req = 0; m0_we = 0;
  endtask

  task automatic do_read(input logic [AB-1:0] a, input logic [W-1:0] exp, input string name);
    bit got = 0;
    m0_req = 1; m0_we = 0; m0_addr = a;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (m0_gnt) got = 1;
      else begin @(posedge clock); #1; end
    end
    if (!got) chk("read_grant_timeout", 0, 1);
    @(posedge clock); #1;
    m0_req = 0;
    @(negedge clock);
    chk({name, "_rvalid"}, m0_rvalid, 1);
    chk(name, m0_rdata, exp);
    @(posedge clock); #1;
  endtask

  // Clear monitor results.
  int busy_cnt, done_cnt, gnt_viol, port_viol, done_gnt0, first_rv0;
  logic [W-1:0] first_rdata;

  // Observe an ongoing clear (already in first CLEAR cycle). Optionally pulse
  // clear_start at busy cycle pulse_at, or assert reset at busy cycle reset_at.
  task automatic watch_clear(input int pulse_at, input int reset_at);
    bit fin = 0;
    busy_cnt = 0; done_cnt = 0; gnt_viol = 0; port_viol = 0; done_gnt0 = 0;
    for (int c = 0; c < 1200 && !fin; c++) begin
      @(negedge clock);
      clear_start = 0;
      if (clear_busy) begin
        busy_cnt++;
        if (busy_cnt == 1) begin first_rv0 = m0_rvalid; first_rdata = m0_rdata; end
        if (m0_gnt || m1_gnt) gnt_viol++;
        if (!ram_enable || !write_enable || input_data != 0 ||
            int'(address) != busy_cnt - 1) port_viol++;
        if (busy_cnt == pulse_at) clear_start = 1;
        if (busy_cnt == reset_at) begin
          reset_n = 0;
          #1;
          chk("reset_mid_clear_busy", clear_busy, 0);
          chk("reset_mid_clear_done", clear_done, 0);
          fin = 1;
        end
      end
      if (clear_done) begin
        done_cnt++;
        done_gnt0 = m0_gnt;
        fin = 1;
      end
    end
    if (!fin) chk("clear_timeout", 0, 1);
  endtask

  typedef struct {
    logic r0, w0; logic [AB-1:0] a0; logic [W-1:0] d0;
    logic r1, w1; logic [AB-1:0] a1; logic [W-1:0] d1;
    logic g0, g1, rv0, rv1, en; logic [W-1:0] rd;
  } vec_t;

  vec_t vecs [15];

  initial begin
    //            r0 w0 a0 d0     r1 w1 a1 d1   g0 g1 rv0 rv1 en rd
    vecs[0]  = '{1, 1, 5, 'hAA, 0, 0, 0, 0,    1, 0, 0, 0, 1, 0};
    vecs[1]  = '{1, 0, 5, 0,    0, 0, 0, 0,    1, 0, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 1, 0, 0, 'hAA};
    vecs[3]  = '{1, 1, 1, 10,   0, 0, 0, 0,    1, 0, 0, 0, 1, 0};
    vecs[4]  = '{0, 0, 0, 0,    1, 1, 2, 20,   0, 1, 0, 0, 1, 0};
    vecs[5]  = '{1, 0, 1, 0,    1, 0, 2, 0,    1, 0, 0, 0, 1, 0};
    vecs[6]  = '{1, 0, 1, 0,    1, 0, 2, 0,    0, 1, 1, 0, 1, 10};
    vecs[7]  = '{1, 0, 1, 0,    1, 0, 2, 0,    1, 0, 0, 1, 1, 20};
    vecs[8]  = '{1, 0, 1, 0,    1, 0, 2, 0,    0, 1, 1, 0, 1, 10};
    vecs[9]  = '{0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 0, 1, 0, 20};
    vecs[10] = '{0, 0, 0, 0,    1, 0, 2, 0,    0, 1, 0, 0, 1, 0};
    vecs[11] = '{0, 0, 0, 0,    1, 0, 2, 0,    0, 1, 0, 1, 1, 20};
    vecs[12] = '{0, 0, 0, 0,    1, 0, 2, 0,    0, 1, 0, 1, 1, 20};
    vecs[13] = '{1, 0, 1, 0,    1, 0, 2, 0,    1, 0, 0, 1, 1, 20};
    vecs[14] = '{0, 0, 0, 0,    0, 0, 0, 0,    0, 0, 1, 0, 0, 10};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_ram_enable", ram_enable, 0);
    chk("rst_write_enable", write_enable, 0);
    chk("rst_address", address, 0);
    reset_n = 1;
    @(posedge clock); #1;

    // Table-driven arbitration / read-return vectors, one row per cycle
    for (int i = 0; i < 15; i++) begin
      m0_req = vecs[i].r0; m0_we = vecs[i].w0; m0_addr = vecs[i].a0; m0_wdata = vecs[i].d0;
      m1_req = vecs[i].r1; m1_we = vecs[i].w1; m1_addr = vecs[i].a1; m1_wdata = vecs[i].d1;
      @(negedge clock);
      chk($sformatf("v%0d_m0_gnt", i), m0_gnt, vecs[i].g0);
      chk($sformatf("v%0d_m1_gnt", i), m1_gnt, vecs[i].g1);
      chk($sformatf("v%0d_m0_rvalid", i), m0_rvalid, vecs[i].rv0);
      chk($sformatf("v%0d_m1_rvalid", i), m1_rvalid, vecs[i].rv1);
      chk($sformatf("v%0d_ram_enable", i), ram_enable, vecs[i].en);
      if (vecs[i].rv0) chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].rd);
      if (vecs[i].rv1) chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].rd);
      @(posedge clock); #1;
    end
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;

    // Clear with m0 held requesting; the clear_start cycle still grants a read.
    for (int a = 0; a < 20; a++) do_write(AB'(a), W'(a * 10));
    m0_req = 1; m0_we = 0; m0_addr = 3; clear_start = 1;
    @(negedge clock);
    chk("clr_start_cycle_m0_gnt", m0_gnt, 1);
    @(posedge clock); #1;
    clear_start = 0; m0_addr = 7;
    watch_clear(0, 0);
    chk("clr_first_cycle_rvalid", first_rv0, 1);
    chk("clr_first_cycle_rdata", first_rdata, 30);
    chk("clr_busy_cycles", busy_cnt, DEPTH);
    chk("clr_done_pulses", done_cnt, 1);
    chk("clr_gnt_during_busy", gnt_viol, 0);
    chk("clr_port_drive_errors", port_viol, 0);
    chk("clr_done_cycle_m0_gnt", done_gnt0, 1);
    @(posedge clock); #1;
    m0_req = 0;
    @(negedge clock);
    chk("clr_after_rvalid", m0_rvalid, 1);
    chk("clr_after_rdata", m0_rdata, 0);
    chk("clr_after_done_low", clear_done, 0);
    @(posedge clock); #1;
    for (int a = 0; a < 20; a++) do_read(AB'(a), 0, $sformatf("cleared_rd%0d", a));

    // Second clear_start during a clear is ignored.
    clear_start = 1;
    @(posedge clock); #1;
    clear_start = 0;
    watch_clear(100, 0);
    chk("restart_busy_cycles", busy_cnt, DEPTH);
    chk("restart_done_pulses", done_cnt, 1);
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (clear_done || clear_busy) done_cnt++;
    end
    chk("restart_no_extra_activity", done_cnt, 0);
    @(posedge clock); #1;

    // Reset in the middle of a clear.
    do_write(100, 'h1234);
    clear_start = 1;
    @(posedge clock); #1;
    clear_start = 0;
    watch_clear(0, 50);
    chk("reset_clear_done_cnt", done_cnt, 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (clear_done || clear_busy) done_cnt++;
    end
    chk("reset_no_done_after", done_cnt, 0);
    @(posedge clock); #1;
    do_read(100, 'h1234, "addr100_kept");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port `bram` block (synchronous, 1-cycle read latency).
- Shares the one BRAM port between master 0 and master 1.
- Returns read data to whichever master issued the read.
- Contains a clear sequencer that zero-fills the whole memory on command while stalling both masters.

Parameters:
- RAM_WIDTH, 32, data word width; must match the attached bram.
- RAM_ADDR_BITS, 9, address width; depth = 2^RAM_ADDR_BITS.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 access request.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  RAM_ADDR_BITS  master 0 address.
- m0_wdata  in  RAM_WIDTH  master 0 write data.
- m0_gnt  out  1  master 0 request accepted this cycle.
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  RAM_WIDTH  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1.
- clear_start  in  1  single-cycle pulse requesting a zero-fill.
- clear_busy  out  1  zero-fill in progress.
- clear_done  out  1  one-cycle pulse when zero-fill completes.
- ram_enable  out  1  to bram ram_enable.
- write_enable  out  1  to bram write_enable.
- address  out  RAM_ADDR_BITS  to bram address.
- input_data  out  RAM_WIDTH  to bram input_data.
- output_data  in  RAM_WIDTH  from bram output_data.

Behaviour:
- **Reset** (asynchronous, reset_n low):
  - state = IDLE, clear counter = 0, last_grant = 1 (so master 0 wins the first tie).
  - m0_rvalid = m1_rvalid = 0, clear_busy = 0, clear_done = 0.
- **BRAM-side outputs:**
  - Combinational from the current grant/state; all four are 0 when nothing is granted and state is IDLE.
  - ram_enable is low on idle cycles, so bram output_data holds its last value.
- **Arbitration (IDLE only):**
  - mX_gnt is combinational, asserted in the same cycle as mX_req.
  - A request is accepted exactly on a cycle with req & gnt. The master must hold req, we, addr and wdata stable until granted.
  - One request alone: it is granted.
  - Both requesting: grant the master that is not last_grant.
  - last_grant updates to the granted master at the clock edge of every grant; it is unchanged on idle cycles.
  - At most one gnt high per cycle.
  - The granted master's we, addr and wdata drive write_enable, address and input_data; ram_enable = 1.
- **Read return:**
  - A granted read sets mX_rvalid = 1 for exactly the next cycle.
  - mX_rdata = output_data combinationally; it is meaningful only while mX_rvalid = 1.
  - Writes never raise rvalid.
  - Back-to-back reads from alternating masters give one rvalid per cycle, in grant order.
- **Clear FSM (states IDLE, CLEAR):**
  - IDLE -> CLEAR: clear_start = 1 at a clock edge. The cycle in which clear_start is high still arbitrates normally; that grant's rvalid appears in the first CLEAR cycle with correct data.
  - In CLEAR: clear_busy = 1, both gnt = 0, ram_enable = 1, write_enable = 1, address = counter, input_data = 0. The counter increments each cycle.
  - CLEAR -> IDLE: after the cycle with counter = 2^RAM_ADDR_BITS-1. The counter returns to 0 and clear_done pulses high for the first IDLE cycle.
  - Arbitration resumes in that same cycle.
  - CLEAR lasts exactly 2^RAM_ADDR_BITS cycles.
  - clear_start while in CLEAR is ignored; no restart, no extra done pulse.
- **Reset mid-clear:** returns immediately to IDLE with no clear_done. Memory is left partially cleared; this is acceptable.
- **Width rules:** the counter is RAM_ADDR_BITS wide and wraps naturally; the terminal value is detected explicitly, never by overflow.

Test Plan:
- Reset, then m0 writes addr 5 = 0xAA, then m0 reads addr 5 -> m0_gnt same cycle as each req; m0_rvalid = 1 the following cycle with m0_rdata = 0xAA; m1_rvalid stays 0.
- m0 and m1 both request reads (addr 1 and 2, preloaded 10 and 20) held continuously for 4 cycles -> grants alternate m0, m1, m0, m1; rvalids alternate with data 10, 20, 10, 20.
- m1 alone requests 3 cycles, then both request -> m0 granted first in the contested cycle (last_grant = 1).
- Fill addrs 0..19 with addr*10, pulse clear_start, hold m0_req during clear -> clear_busy high exactly 512 cycles, no gnt throughout; clear_done pulses once; m0 granted in the done cycle; reads of 0..19 then return 0.
- clear_start pulsed again at cycle 100 of a clear -> total busy still 512 cycles, single clear_done.
- reset_n asserted at cycle 50 of a clear -> clear_busy drops immediately, no clear_done; addr 100 still holds its pre-clear value on readback.
